// File: rtl/pipeline_stall_controller.sv
// rtl/pipeline_stall_controller.sv - prioritised stall/bubble/flush sequencing for the 5-stage pipeline
module pipeline_stall_controller #(
    parameter int FLUSH_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_hazard_detected,
    input  logic             i_branch_taken,
    input  logic             i_mem_req,
    input  logic             i_mem_ready,
    input  logic             i_clr_stats,
    output logic             o_freeze_all,
    output logic             o_freeze_if,
    output logic             o_bubble_id,
    output logic             o_flush_if,
    output logic [CNT_W-1:0] o_stall_cycles
);

    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_MEM_WAIT = 2'd1,
        S_FLUSH    = 2'd2
    } state_t;

    state_t           r_state;
    state_t           r_ret_state;
    state_t           w_next_state;
    state_t           w_next_ret;
    state_t           w_eff_state;
    logic [2:0]       r_flush_cnt;
    logic [2:0]       w_next_flush_cnt;
    logic [CNT_W-1:0] r_stall_cycles;
    logic             w_mem_wait;
    logic             w_stalled;

    assign w_mem_wait = i_mem_req & ~i_mem_ready;
    // The ready cycle of a memory wait behaves exactly like the state it interrupted.
    assign w_eff_state = (r_state == S_MEM_WAIT) ? r_ret_state : r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_RUN;
            r_ret_state <= S_RUN;
            r_flush_cnt <= 3'd0;
        end else begin
            r_state     <= w_next_state;
            r_ret_state <= w_next_ret;
            r_flush_cnt <= w_next_flush_cnt;
        end
    end

    always_comb begin
        w_next_state     = r_state;
        w_next_ret       = r_ret_state;
        w_next_flush_cnt = r_flush_cnt;
        o_freeze_all     = 1'b0;
        o_freeze_if      = 1'b0;
        o_bubble_id      = 1'b0;
        o_flush_if       = 1'b0;
        if (rst) begin
            w_next_state = S_RUN;
        end else if (w_mem_wait) begin
            o_freeze_all = 1'b1;
            w_next_state = S_MEM_WAIT;
            if (r_state != S_MEM_WAIT) begin
                w_next_ret = r_state;
            end
        end else if (w_eff_state == S_FLUSH) begin
            o_flush_if       = 1'b1;
            o_bubble_id      = 1'b1;
            w_next_flush_cnt = r_flush_cnt - 3'd1;
            w_next_state     = (r_flush_cnt == 3'd1) ? S_RUN : S_FLUSH;
        end else begin
            w_next_state = S_RUN;
            if (i_branch_taken) begin
                o_flush_if  = 1'b1;
                o_bubble_id = 1'b1;
                if (FLUSH_CYCLES > 1) begin
                    w_next_state     = S_FLUSH;
                    w_next_flush_cnt = 3'(FLUSH_CYCLES - 1);
                end
            end else if (i_hazard_detected) begin
                o_freeze_if = 1'b1;
                o_bubble_id = 1'b1;
            end
        end
    end

    assign w_stalled = o_freeze_all | o_freeze_if;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_cycles <= '0;
        end else if (i_clr_stats) begin
            r_stall_cycles <= '0;
        end else if (w_stalled && !(&r_stall_cycles)) begin
            r_stall_cycles <= r_stall_cycles + CNT_W'(1);
        end
    end

    assign o_stall_cycles = r_stall_cycles;

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// tb/tb_pipeline_stall_controller.sv - directed self-checking bench for pipeline_stall_controller
module tb_pipeline_stall_controller;

    logic       clk;
    logic       rst;
    logic       hz, br, mreq, mrdy, clr;
    logic       fa, fi, bi, fl;
    logic [3:0] sc;
    logic       d1_fa, d1_fi, d1_bi, d1_fl;
    logic [15:0] d1_sc;
    int         checks;
    int         errors;

    pipeline_stall_controller #(.FLUSH_CYCLES(3), .CNT_W(4)) u_dut (
        .clk(clk), .rst(rst),
        .i_hazard_detected(hz), .i_branch_taken(br),
        .i_mem_req(mreq), .i_mem_ready(mrdy), .i_clr_stats(clr),
        .o_freeze_all(fa), .o_freeze_if(fi), .o_bubble_id(bi), .o_flush_if(fl),
        .o_stall_cycles(sc)
    );

    pipeline_stall_controller #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .rst(rst),
        .i_hazard_detected(hz), .i_branch_taken(br),
        .i_mem_req(mreq), .i_mem_ready(mrdy), .i_clr_stats(clr),
        .o_freeze_all(d1_fa), .o_freeze_if(d1_fi), .o_bubble_id(d1_bi), .o_flush_if(d1_fl),
        .o_stall_cycles(d1_sc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic drive(input logic h, input logic b, input logic q, input logic r, input logic c);
        @(negedge clk);
        hz = h; br = b; mreq = q; mrdy = r; clr = c;
        #1;
    endtask

    task automatic test_reset;
        rst = 1'b1; hz = 1'b1; br = 1'b0; mreq = 1'b0; mrdy = 1'b0; clr = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        checks++; if ({fa, fi, bi, fl} !== 4'b0000) begin
            errors++; $display("FAIL reset_outputs got %b expected 0000", {fa, fi, bi, fl});
        end
        checks++; if (sc !== 4'd0) begin
            errors++; $display("FAIL reset_stall_cycles got %0d expected 0", sc);
        end
        rst = 1'b0;
        #1;
        checks++; if ({fi, bi} !== 2'b11) begin
            errors++; $display("FAIL reset_release_hazard got %b expected 11", {fi, bi});
        end
        checks++; if ({fa, fl} !== 2'b00) begin
            errors++; $display("FAIL reset_release_other got %b expected 00", {fa, fl});
        end
    endtask

    task automatic test_hazard;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 2; i++) begin
            drive(1, 0, 0, 0, 0);
            checks++; if ({fa, fi, bi, fl} !== 4'b0110) begin
                errors++; $display("FAIL hazard_cycle%0d got %b expected 0110", i, {fa, fi, bi, fl});
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++; if ({fa, fi, bi, fl} !== 4'b0000) begin
            errors++; $display("FAIL hazard_end got %b expected 0000", {fa, fi, bi, fl});
        end
        checks++; if (sc !== 4'd2) begin
            errors++; $display("FAIL hazard_stall_cycles got %0d expected 2", sc);
        end
    endtask

    task automatic test_branch;
        drive(0, 0, 0, 0, 1);
        drive(1, 1, 0, 0, 0);
        checks++; if ({fa, fi, bi, fl} !== 4'b0011) begin
            errors++; $display("FAIL branch_cycle0 got %b expected 0011", {fa, fi, bi, fl});
        end
        for (int i = 1; i < 3; i++) begin
            drive(1, 0, 0, 0, 0);
            checks++; if ({fa, fi, bi, fl} !== 4'b0011) begin
                errors++; $display("FAIL branch_cycle%0d got %b expected 0011", i, {fa, fi, bi, fl});
            end
            if (i == 1) begin
                checks++; if ({d1_fi, d1_fl} !== 2'b10) begin
                    errors++; $display("FAIL flush1_no_flush_state got %b expected 10", {d1_fi, d1_fl});
                end
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++; if ({fa, fi, bi, fl} !== 4'b0000) begin
            errors++; $display("FAIL branch_end got %b expected 0000", {fa, fi, bi, fl});
        end
        checks++; if (sc !== 4'd0) begin
            errors++; $display("FAIL branch_stall_cycles got %0d expected 0", sc);
        end
    endtask

    task automatic test_mem_wait;
        drive(0, 0, 0, 0, 1);
        for (int i = 0; i < 3; i++) begin
            drive(i == 1, 0, 1, 0, 0);
            checks++; if ({fa, fi, bi, fl} !== 4'b1000) begin
                errors++; $display("FAIL mem_wait_cycle%0d got %b expected 1000", i, {fa, fi, bi, fl});
            end
        end
        drive(0, 0, 1, 1, 0);
        checks++; if (fa !== 1'b0) begin
            errors++; $display("FAIL mem_ready_cycle freeze_all got %b expected 0", fa);
        end
        checks++; if (sc !== 4'd3) begin
            errors++; $display("FAIL mem_stall_cycles got %0d expected 3", sc);
        end
        drive(0, 0, 1, 1, 0);
        checks++; if (fa !== 1'b0) begin
            errors++; $display("FAIL mem_single_cycle freeze_all got %b expected 0", fa);
        end
        drive(0, 0, 0, 1, 0);
        checks++; if ({fa, fi, bi, fl} !== 4'b0000) begin
            errors++; $display("FAIL mem_ready_no_req got %b expected 0000", {fa, fi, bi, fl});
        end
    endtask

    task automatic test_branch_under_freeze;
        for (int i = 0; i < 2; i++) begin
            drive(0, 1, 1, 0, 0);
            checks++; if ({fa, fl} !== 2'b10) begin
                errors++; $display("FAIL brfrz_frozen%0d got %b expected 10", i, {fa, fl});
            end
        end
        drive(0, 1, 1, 1, 0);
        checks++; if ({fa, bi, fl} !== 3'b011) begin
            errors++; $display("FAIL brfrz_ready got %b expected 011", {fa, bi, fl});
        end
        for (int i = 0; i < 2; i++) begin
            drive(0, 0, 0, 0, 0);
            checks++; if ({fa, bi, fl} !== 3'b011) begin
                errors++; $display("FAIL brfrz_flush%0d got %b expected 011", i, {fa, bi, fl});
            end
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (fl !== 1'b0) begin
            errors++; $display("FAIL brfrz_end flush_if got %b expected 0", fl);
        end
    endtask

    task automatic test_freeze_in_flush;
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        checks++; if ({fa, fl} !== 2'b10) begin
            errors++; $display("FAIL flushfrz_frozen got %b expected 10", {fa, fl});
        end
        drive(1, 0, 1, 1, 0);
        checks++; if ({fa, fi, fl} !== 3'b001) begin
            errors++; $display("FAIL flushfrz_resume got %b expected 001", {fa, fi, fl});
        end
        drive(0, 0, 0, 0, 0);
        checks++; if (fl !== 1'b0) begin
            errors++; $display("FAIL flushfrz_end flush_if got %b expected 0", fl);
        end
    endtask

    task automatic test_reset_mid_flush;
        drive(0, 1, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        rst = 1'b1;
        #1;
        checks++; if ({fa, fi, bi, fl} !== 4'b0000) begin
            errors++; $display("FAIL rst_mid_flush got %b expected 0000", {fa, fi, bi, fl});
        end
        @(negedge clk);
        rst = 1'b0;
        #1;
        checks++; if ({bi, fl} !== 2'b00) begin
            errors++; $display("FAIL rst_mid_flush_after got %b expected 00", {bi, fl});
        end
    endtask

    task automatic test_saturation;
        drive(0, 0, 0, 0, 1);
        repeat (20) drive(1, 0, 0, 0, 0);
        drive(0, 0, 0, 0, 0);
        checks++; if (sc !== 4'd15) begin
            errors++; $display("FAIL sat_stall_cycles got %0d expected 15", sc);
        end
        checks++; if (d1_sc !== 16'd20) begin
            errors++; $display("FAIL wide_stall_cycles got %0d expected 20", d1_sc);
        end
        drive(1, 0, 0, 0, 1);
        drive(0, 0, 0, 0, 0);
        checks++; if (sc !== 4'd0) begin
            errors++; $display("FAIL clr_stats got %0d expected 0", sc);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_hazard();
        test_branch();
        test_mem_wait();
        test_branch_under_freeze();
        test_freeze_in_flush();
        test_reset_mid_flush();
        test_saturation();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
